// File: rtl/rv32i_alu_pkg.sv
// Shared types for the RV32I ALU: operation encodings, word type and
// the shifter direction select.
package rv32i_alu_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] rv32i_word;

    // Encodings match the EX-stage decode; all eight are legal operations.
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SLL = 3'b001,
        ALU_SRA = 3'b010,
        ALU_SUB = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SRL = 3'b101,
        ALU_OR  = 3'b110,
        ALU_AND = 3'b111
    } alu_ops;

    typedef enum logic {
        SHIFT_RIGHT = 1'b0,
        SHIFT_LEFT  = 1'b1
    } shift_dir_e;

    // Subtraction reuses the adder with operand B inverted and a carry-in of 1.
    function automatic logic alu_op_is_sub(input alu_ops op);
        return (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/rv32i_alu_shifter.sv
// Log-stage barrel shifter serving sll/srl/sra. Left shifts are done by
// bit-reversing the input, shifting right with zero fill and reversing back,
// so a single right-shifting stage chain covers all three operations.
module rv32i_alu_shifter
    import rv32i_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   shamt,
    input  shift_dir_e       dir,
    input  logic             arith,
    output logic [WIDTH-1:0] result
);

    function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    logic [WIDTH-1:0] stage [SHW+1];
    logic             fill;

    // Sign fill only applies to arithmetic right shifts; everything else fills with zero.
    assign fill     = arith & (dir == SHIFT_RIGHT) & data[WIDTH-1];
    assign stage[0] = (dir == SHIFT_LEFT) ? bit_reverse(data) : data;

    // Stage k shifts right by 2**k when shamt bit k is set.
    genvar k;
    for (k = 0; k < SHW; k++) begin : g_stage
        localparam int S = 1 << k;
        assign stage[k+1] = shamt[k] ? {{S{fill}}, stage[k][WIDTH-1:S]} : stage[k];
    end

    assign result = (dir == SHIFT_LEFT) ? bit_reverse(stage[SHW]) : stage[SHW];

endmodule

// File: rtl/rv32i_alu.sv
// RV32I integer ALU. f/zero are purely combinational for the EX/MEM latch;
// f_q/zero_q/valid_q are an optional registered copy for slower consumers.
//
// Valid semantics: in_valid qualifies aluop/a/b for the registered stage only.
// On a clock edge with in_valid=1 the current f/zero are captured; with
// in_valid=0 the captured values are held. valid_q is in_valid delayed by one
// edge. There is no ready: the consumer can never stall the ALU.
module rv32i_alu
    import rv32i_alu_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  alu_ops           aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] f,
    output logic             zero,
    output logic [WIDTH-1:0] f_q,
    output logic             zero_q,
    output logic             valid_q
);

    localparam int SHW = $clog2(WIDTH);

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] shift_res;
    shift_dir_e       shift_dir;
    logic             shift_arith;

    // Shared adder: a + b for add, a + ~b + 1 for sub; carry-out is dropped so both wrap.
    assign is_sub = alu_op_is_sub(aluop);
    assign b_eff  = is_sub ? ~b : b;
    assign sum    = a + b_eff + WIDTH'(is_sub);

    // Shifter control derived from the opcode; only sll shifts left, only sra sign-fills.
    always_comb begin
        shift_dir   = SHIFT_RIGHT;
        shift_arith = 1'b0;
        if (aluop == ALU_SLL) shift_dir = SHIFT_LEFT;
        if (aluop == ALU_SRA) shift_arith = 1'b1;
    end

    rv32i_alu_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .data   (a),
        .shamt  (b[SHW-1:0]),
        .dir    (shift_dir),
        .arith  (shift_arith),
        .result (shift_res)
    );

    // Result select; every encoding maps to a defined operation.
    always_comb begin
        f = sum;
        case (aluop)
            ALU_ADD: f = sum;
            ALU_SUB: f = sum;
            ALU_SLL: f = shift_res;
            ALU_SRA: f = shift_res;
            ALU_SRL: f = shift_res;
            ALU_XOR: f = a ^ b;
            ALU_OR:  f = a | b;
            ALU_AND: f = a & b;
            default: f = sum;
        endcase
    end

    assign zero = (f == '0);

    // Registered copy: capture on qualified cycles, hold otherwise; reset clears immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q     <= '0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (in_valid) begin
                f_q    <= f;
                zero_q <= zero;
            end
            valid_q <= in_valid;
        end
    end

endmodule

// File: tb/tb_rv32i_alu.sv
// Directed testbench for rv32i_alu: combinational ops with hand-computed
// results, registered capture/hold, and asynchronous reset behaviour.
module tb_rv32i_alu;
    import rv32i_alu_pkg::*;

    typedef struct {
        alu_ops      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] f;
        logic        z;
    } vec_t;

    logic        clk;
    logic        rst;
    alu_ops      aluop;
    logic [31:0] a;
    logic [31:0] b;
    logic        in_valid;
    logic [31:0] f;
    logic        zero;
    logic [31:0] f_q;
    logic        zero_q;
    logic        valid_q;

    int checks = 0;
    int errors = 0;

    rv32i_alu #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .aluop    (aluop),
        .a        (a),
        .b        (b),
        .in_valid (in_valid),
        .f        (f),
        .zero     (zero),
        .f_q      (f_q),
        .zero_q   (zero_q),
        .valid_q  (valid_q)
    );

    // Clock and initial reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: apply inputs just after a falling edge so they are stable well before capture.
    task automatic drive(input alu_ops op, input logic [31:0] x, input logic [31:0] y,
                         input logic v);
        @(negedge clk);
        aluop    = op;
        a        = x;
        b        = y;
        in_valid = v;
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (f_q !== 32'h0 || zero_q !== 1'b0 || valid_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_state f_q=%h zero_q=%b valid_q=%b want 0/0/0", f_q, zero_q, valid_q);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add_sub();
        vec_t v[6];
        v = '{
            '{ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0},
            '{ALU_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1},
            '{ALU_ADD, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0},
            '{ALU_SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0},
            '{ALU_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1},
            '{ALU_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0}
        };
        for (int i = 0; i < 6; i++) begin
            drive(v[i].op, v[i].a, v[i].b, 1'b0);
            checks++;
            if (f !== v[i].f || zero !== v[i].z) begin
                errors++;
                $display("FAIL add_sub[%0d] f=%h zero=%b want f=%h zero=%b", i, f, zero, v[i].f, v[i].z);
            end
        end
    endtask

    task automatic test_shift();
        vec_t v[8];
        v = '{
            '{ALU_SRA, 32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0},
            '{ALU_SRL, 32'h80000000, 32'd31,       32'h00000001, 1'b0},
            '{ALU_SLL, 32'h00000001, 32'h00000021, 32'h00000002, 1'b0},
            '{ALU_SRA, 32'h80000000, 32'hFFFFFFE4, 32'hF8000000, 1'b0},
            '{ALU_SRA, 32'h7FFFFFFF, 32'd4,        32'h07FFFFFF, 1'b0},
            '{ALU_SLL, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 1'b0},
            '{ALU_SLL, 32'h0000000F, 32'd30,       32'hC0000000, 1'b0},
            '{ALU_SRL, 32'h00000001, 32'd1,        32'h00000000, 1'b1}
        };
        for (int i = 0; i < 8; i++) begin
            drive(v[i].op, v[i].a, v[i].b, 1'b0);
            checks++;
            if (f !== v[i].f || zero !== v[i].z) begin
                errors++;
                $display("FAIL shift[%0d] f=%h zero=%b want f=%h zero=%b", i, f, zero, v[i].f, v[i].z);
            end
        end
    endtask

    task automatic test_logic();
        vec_t v[4];
        v = '{
            '{ALU_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0},
            '{ALU_OR,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0},
            '{ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0},
            '{ALU_AND, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 1'b1}
        };
        for (int i = 0; i < 4; i++) begin
            drive(v[i].op, v[i].a, v[i].b, 1'b0);
            checks++;
            if (f !== v[i].f || zero !== v[i].z) begin
                errors++;
                $display("FAIL logic[%0d] f=%h zero=%b want f=%h zero=%b", i, f, zero, v[i].f, v[i].z);
            end
        end
    endtask

    task automatic test_registered();
        // Capture 3+4 with in_valid high.
        drive(ALU_ADD, 32'd3, 32'd4, 1'b1);
        checks++;
        if (f !== 32'd7) begin
            errors++;
            $display("FAIL reg_comb f=%h want %h", f, 32'd7);
        end
        @(posedge clk);
        #1;
        checks++;
        if (f_q !== 32'd7 || zero_q !== 1'b0 || valid_q !== 1'b1) begin
            errors++;
            $display("FAIL reg_capture f_q=%h zero_q=%b valid_q=%b want 7/0/1", f_q, zero_q, valid_q);
        end
        // Unqualified cycle: new inputs must not be captured, valid_q drops.
        drive(ALU_SUB, 32'd9, 32'd9, 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (f_q !== 32'd7 || zero_q !== 1'b0 || valid_q !== 1'b0) begin
            errors++;
            $display("FAIL reg_hold f_q=%h zero_q=%b valid_q=%b want 7/0/0", f_q, zero_q, valid_q);
        end
        // Back-to-back qualified captures, second one producing zero.
        drive(ALU_OR, 32'h00F0, 32'h000F, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (f_q !== 32'h00FF || valid_q !== 1'b1) begin
            errors++;
            $display("FAIL reg_b2b_0 f_q=%h valid_q=%b want 000000ff/1", f_q, valid_q);
        end
        drive(ALU_SUB, 32'd5, 32'd5, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (f_q !== 32'h0 || zero_q !== 1'b1 || valid_q !== 1'b1) begin
            errors++;
            $display("FAIL reg_b2b_1 f_q=%h zero_q=%b valid_q=%b want 0/1/1", f_q, zero_q, valid_q);
        end
        // Restore f_q=7 and hold it for the reset test.
        drive(ALU_ADD, 32'd3, 32'd4, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (f_q !== 32'd7 || zero_q !== 1'b0) begin
            errors++;
            $display("FAIL reg_reload f_q=%h zero_q=%b want 7/0", f_q, zero_q);
        end
    endtask

    task automatic test_async_reset();
        // Assert reset between edges while the input is still valid-looking.
        @(negedge clk);
        in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (f_q !== 32'h0 || zero_q !== 1'b0 || valid_q !== 1'b0) begin
            errors++;
            $display("FAIL async_rst f_q=%h zero_q=%b valid_q=%b want 0/0/0", f_q, zero_q, valid_q);
        end
        checks++;
        if (f !== 32'd7 || zero !== 1'b0) begin
            errors++;
            $display("FAIL rst_comb f=%h zero=%b want 00000007/0", f, zero);
        end
        // f keeps following inputs while reset is held.
        aluop = ALU_SUB;
        a     = 32'd10;
        b     = 32'd5;
        #1;
        checks++;
        if (f !== 32'd5) begin
            errors++;
            $display("FAIL rst_comb_live f=%h want %h", f, 32'd5);
        end
        // Edges during reset must not capture.
        @(posedge clk);
        #1;
        checks++;
        if (f_q !== 32'h0 || valid_q !== 1'b0) begin
            errors++;
            $display("FAIL rst_hold f_q=%h valid_q=%b want 0/0", f_q, valid_q);
        end
        // First capture on the first rising edge after release.
        @(negedge clk);
        rst   = 1'b0;
        aluop = ALU_ADD;
        a     = 32'd1;
        b     = 32'd1;
        @(posedge clk);
        #1;
        checks++;
        if (f_q !== 32'd2 || valid_q !== 1'b1) begin
            errors++;
            $display("FAIL rst_release f_q=%h valid_q=%b want 2/1", f_q, valid_q);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        aluop    = ALU_ADD;
        a        = '0;
        b        = '0;
        in_valid = 1'b0;
        test_reset();
        test_add_sub();
        test_shift();
        test_logic();
        test_registered();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
